// File: rtl/seq_sorter_pkg.sv
// Shared FSM encoding and width helpers for the sequential odd-even transposition sorter.
package seq_sorter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sort_cas.sv
// Combinational compare-and-swap of one adjacent pair; zero latency, no flow control.
// o_lo lands at the lower position; equal keys never swap so ordering stays stable.
module sort_cas
    import seq_sorter_pkg::*;
#(
    parameter int WIDTH = 8
`ifdef SEQ_SORTER_IDX_EN
    ,
    parameter int IDXW  = 2
`endif
) (
    input  logic             i_descend,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
`ifdef SEQ_SORTER_IDX_EN
    input  logic [IDXW-1:0]  i_ia,
    input  logic [IDXW-1:0]  i_ib,
    output logic [IDXW-1:0]  o_ilo,
    output logic [IDXW-1:0]  o_ihi,
`endif
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);

    logic w_swap;

    assign w_swap = i_descend ? (i_a < i_b) : (i_a > i_b);
    assign o_lo   = w_swap ? i_b : i_a;
    assign o_hi   = w_swap ? i_a : i_b;

`ifdef SEQ_SORTER_IDX_EN
    assign o_ilo  = w_swap ? i_ib : i_ia;
    assign o_ihi  = w_swap ? i_ia : i_ib;
`endif

endmodule

// File: rtl/seq_sorter.sv
// Sorts one N-element vector in N cycles (one odd-even phase per cycle); holds result until out_ready.
// Accepts only when idle, no overlap. Define SEQ_SORTER_IDX_EN to add out_idx source-position tracking.
module seq_sorter
    import seq_sorter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int N       = 4,
    parameter int DESCEND = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*WIDTH-1:0]      in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*WIDTH-1:0]      out_data,
`ifdef SEQ_SORTER_IDX_EN
    output logic [N*idx_width(N)-1:0] out_idx,
`endif
    output logic                    busy
);

    localparam int   CW     = cnt_width(N);
    localparam logic L_DESC = (DESCEND != 0);
`ifdef SEQ_SORTER_IDX_EN
    localparam int   IDXW   = idx_width(N);
`endif

    state_t           r_state;
    logic [CW-1:0]    r_phase;
    logic [WIDTH-1:0] r_elem [N];
    logic [WIDTH-1:0] w_nxt  [N];
    logic [WIDTH-1:0] w_lo   [N-1];
    logic [WIDTH-1:0] w_hi   [N-1];
    logic [N-2:0]     w_act;
    logic             w_last;

`ifdef SEQ_SORTER_IDX_EN
    logic [IDXW-1:0]  r_idx  [N];
    logic [IDXW-1:0]  w_inxt [N];
    logic [IDXW-1:0]  w_ilo  [N-1];
    logic [IDXW-1:0]  w_ihi  [N-1];
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == SORT);
    assign w_last    = (r_phase == CW'(N - 1));

    // Pair (j,j+1) is active when j has the same parity as the current phase.
    for (genvar j = 0; j < N - 1; j++) begin : g_cas
        assign w_act[j] = (r_phase[0] == ((j % 2) == 1));

        sort_cas #(
            .WIDTH (WIDTH)
`ifdef SEQ_SORTER_IDX_EN
            ,
            .IDXW  (IDXW)
`endif
        ) u_cas (
            .i_descend (L_DESC),
            .i_a       (r_elem[j]),
            .i_b       (r_elem[j+1]),
`ifdef SEQ_SORTER_IDX_EN
            .i_ia      (r_idx[j]),
            .i_ib      (r_idx[j+1]),
            .o_ilo     (w_ilo[j]),
            .o_ihi     (w_ihi[j]),
`endif
            .o_lo      (w_lo[j]),
            .o_hi      (w_hi[j])
        );
    end

    for (genvar i = 0; i < N; i++) begin : g_nxt
        if (i == 0) begin : g_first
            assign w_nxt[i] = w_act[0] ? w_lo[0] : r_elem[0];
`ifdef SEQ_SORTER_IDX_EN
            assign w_inxt[i] = w_act[0] ? w_ilo[0] : r_idx[0];
`endif
        end else if (i == N - 1) begin : g_tail
            assign w_nxt[i] = w_act[i-1] ? w_hi[i-1] : r_elem[i];
`ifdef SEQ_SORTER_IDX_EN
            assign w_inxt[i] = w_act[i-1] ? w_ihi[i-1] : r_idx[i];
`endif
        end else begin : g_mid
            assign w_nxt[i] = w_act[i-1] ? w_hi[i-1] :
                              (w_act[i] ? w_lo[i] : r_elem[i]);
`ifdef SEQ_SORTER_IDX_EN
            assign w_inxt[i] = w_act[i-1] ? w_ihi[i-1] :
                               (w_act[i] ? w_ilo[i] : r_idx[i]);
`endif
        end

        assign out_data[i*WIDTH +: WIDTH] = r_elem[i];
`ifdef SEQ_SORTER_IDX_EN
        assign out_idx[i*IDXW +: IDXW] = r_idx[i];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_phase <= '0;
            for (int i = 0; i < N; i++) begin
                r_elem[i] <= '0;
`ifdef SEQ_SORTER_IDX_EN
                r_idx[i]  <= '0;
`endif
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state <= SORT;
                        r_phase <= '0;
                        for (int i = 0; i < N; i++) begin
                            r_elem[i] <= in_data[i*WIDTH +: WIDTH];
`ifdef SEQ_SORTER_IDX_EN
                            r_idx[i]  <= IDXW'(i);
`endif
                        end
                    end
                end
                SORT: begin
                    r_phase <= r_phase + 1'b1;
                    for (int i = 0; i < N; i++) begin
                        r_elem[i] <= w_nxt[i];
`ifdef SEQ_SORTER_IDX_EN
                        r_idx[i]  <= w_inxt[i];
`endif
                    end
                    if (w_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_sorter.sv
// Scoreboard bench: ascending and descending N=4 sorters plus an N=2 ascending sorter.
module tb_seq_sorter;

    typedef struct {
        logic [31:0] dat;
        logic [7:0]  idx;
    } exp_t;

    logic clk;
    logic rst;

    logic        a_vld, a_rdy, a_ovld, a_ordy, a_busy;
    logic [31:0] a_dat, a_odat;
    logic        d_vld, d_rdy, d_ovld, d_ordy, d_busy;
    logic [31:0] d_dat, d_odat;
    logic        t_vld, t_rdy, t_ovld, t_ordy, t_busy;
    logic [15:0] t_dat, t_odat;
`ifdef SEQ_SORTER_IDX_EN
    logic [7:0]  a_oidx, d_oidx;
    logic [1:0]  t_oidx;
`endif

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    seq_sorter #(.WIDTH(8), .N(4), .DESCEND(0)) u_asc (
        .clk(clk), .rst(rst), .in_valid(a_vld), .in_ready(a_rdy), .in_data(a_dat),
        .out_valid(a_ovld), .out_ready(a_ordy), .out_data(a_odat),
`ifdef SEQ_SORTER_IDX_EN
        .out_idx(a_oidx),
`endif
        .busy(a_busy)
    );

    seq_sorter #(.WIDTH(8), .N(4), .DESCEND(1)) u_desc (
        .clk(clk), .rst(rst), .in_valid(d_vld), .in_ready(d_rdy), .in_data(d_dat),
        .out_valid(d_ovld), .out_ready(d_ordy), .out_data(d_odat),
`ifdef SEQ_SORTER_IDX_EN
        .out_idx(d_oidx),
`endif
        .busy(d_busy)
    );

    seq_sorter #(.WIDTH(8), .N(2), .DESCEND(0)) u_two (
        .clk(clk), .rst(rst), .in_valid(t_vld), .in_ready(t_rdy), .in_data(t_dat),
        .out_valid(t_ovld), .out_ready(t_ordy), .out_data(t_odat),
`ifdef SEQ_SORTER_IDX_EN
        .out_idx(t_oidx),
`endif
        .busy(t_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: stable insertion sort, strict compare only.
    task automatic model(input logic [31:0] v, input bit desc,
                         output logic [31:0] od, output logic [7:0] oi);
        int e[4];
        int x[4];
        for (int i = 0; i < 4; i++) begin
            e[i] = int'(v[i*8 +: 8]);
            x[i] = i;
        end
        for (int i = 1; i < 4; i++) begin
            int k  = e[i];
            int kx = x[i];
            int j  = i - 1;
            while (j >= 0 && (desc ? (e[j] < k) : (e[j] > k))) begin
                e[j+1] = e[j];
                x[j+1] = x[j];
                j--;
            end
            e[j+1] = k;
            x[j+1] = kx;
        end
        for (int i = 0; i < 4; i++) begin
            od[i*8 +: 8] = 8'(e[i]);
            oi[i*2 +: 2] = 2'(x[i]);
        end
    endtask

    task automatic run4(input bit sel_desc, input logic [31:0] vec,
                        input logic [31:0] ed, input logic [7:0] ei, input string name);
        exp_t e;
        int   lat;
        exp_q.push_back('{dat: ed, idx: ei});
        if (sel_desc) begin d_vld = 1'b1; d_dat = vec; end
        else          begin a_vld = 1'b1; a_dat = vec; end
        @(posedge clk);
        @(negedge clk);
        a_vld = 1'b0;
        d_vld = 1'b0;
        n_checks++;
        if ((sel_desc ? d_busy : a_busy) !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy: got %b want 1", name, sel_desc ? d_busy : a_busy);
        end
        lat = 0;
        while ((sel_desc ? d_ovld : a_ovld) !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want 4", name, lat);
        end
        e = exp_q.pop_front();
        n_checks++;
        if ((sel_desc ? d_odat : a_odat) !== e.dat) begin
            n_fail++;
            $display("FAIL %s data: got %h want %h", name, sel_desc ? d_odat : a_odat, e.dat);
        end
`ifdef SEQ_SORTER_IDX_EN
        n_checks++;
        if ((sel_desc ? d_oidx : a_oidx) !== e.idx) begin
            n_fail++;
            $display("FAIL %s idx: got %h want %h", name, sel_desc ? d_oidx : a_oidx, e.idx);
        end
`endif
        if (sel_desc) d_ordy = 1'b1; else a_ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_ordy = 1'b0;
        d_ordy = 1'b0;
        n_checks++;
        if ((sel_desc ? {d_rdy, d_ovld} : {a_rdy, a_ovld}) !== 2'b10) begin
            n_fail++;
            $display("FAIL %s release: got rdy/vld %b want 10", name,
                     sel_desc ? {d_rdy, d_ovld} : {a_rdy, a_ovld});
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({a_rdy, a_ovld, a_busy, d_rdy, d_ovld, d_busy, t_rdy, t_ovld, t_busy} !== 9'b100100100) begin
            n_fail++;
            $display("FAIL reset flags: got %b want 100100100",
                     {a_rdy, a_ovld, a_busy, d_rdy, d_ovld, d_busy, t_rdy, t_ovld, t_busy});
        end
        n_checks++;
        if ({a_odat, d_odat, t_odat} !== 80'h0) begin
            n_fail++;
            $display("FAIL reset data: got %h want 0", {a_odat, d_odat, t_odat});
        end
`ifdef SEQ_SORTER_IDX_EN
        n_checks++;
        if ({a_oidx, d_oidx, t_oidx} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset idx: got %h want 0", {a_oidx, d_oidx, t_oidx});
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_spec_vectors;
        run4(1'b0, {8'd3, 8'd25, 8'd48, 8'd6}, {8'd48, 8'd25, 8'd6, 8'd3},
             {2'd1, 2'd2, 2'd0, 2'd3}, "asc_basic");
        run4(1'b1, {8'd3, 8'd25, 8'd48, 8'd6}, {8'd3, 8'd6, 8'd25, 8'd48},
             {2'd3, 2'd0, 2'd2, 2'd1}, "desc_basic");
        run4(1'b0, {8'd7, 8'd2, 8'd7, 8'd7}, {8'd7, 8'd7, 8'd7, 8'd2},
             {2'd3, 2'd1, 2'd0, 2'd2}, "ties_stable");
        run4(1'b0, {4{8'd5}}, {4{8'd5}}, {2'd3, 2'd2, 2'd1, 2'd0}, "all_equal");
        run4(1'b0, {4{8'd255}}, {4{8'd255}}, {2'd3, 2'd2, 2'd1, 2'd0}, "all_255_asc");
        run4(1'b1, {4{8'd255}}, {4{8'd255}}, {2'd3, 2'd2, 2'd1, 2'd0}, "all_255_desc");
    endtask

    task automatic test_backpressure;
        int lat;
        a_vld = 1'b1;
        a_dat = {8'd7, 8'd8, 8'd9, 8'd10};
        @(posedge clk);
        @(negedge clk);
        a_dat = {8'd1, 8'd2, 8'd3, 8'd4};
        lat = 0;
        while (a_ovld !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL bp latency: got %0d want 4", lat);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if ({a_rdy, a_ovld} !== 2'b01 || a_odat !== {8'd10, 8'd9, 8'd8, 8'd7}) begin
                n_fail++;
                $display("FAIL bp hold cycle %0d: got rdy/vld %b data %h want 01 0a090807",
                         c, {a_rdy, a_ovld}, a_odat);
            end
        end
        a_vld  = 1'b0;
        a_ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_ordy = 1'b0;
        n_checks++;
        if ({a_rdy, a_ovld, a_busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL bp release: got rdy/vld/busy %b want 100", {a_rdy, a_ovld, a_busy});
        end
        @(negedge clk);
        n_checks++;
        if (a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp no second accept: busy %b want 0", a_busy);
        end
    endtask

    task automatic test_reset_mid_sort;
        a_vld = 1'b1;
        a_dat = {8'd11, 8'd22, 8'd33, 8'd44};
        @(posedge clk);
        @(negedge clk);
        a_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({a_rdy, a_ovld, a_busy} !== 3'b100 || a_odat !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_sort reset: got rdy/vld/busy %b data %h want 100 0",
                     {a_rdy, a_ovld, a_busy}, a_odat);
        end
        @(negedge clk);
        rst = 1'b0;
        run4(1'b0, {8'd1, 8'd128, 8'd0, 8'd255}, {8'd255, 8'd128, 8'd1, 8'd0},
             {2'd0, 2'd2, 2'd3, 2'd1}, "after_reset");
    endtask

    task automatic test_n2;
        int lat;
        t_vld = 1'b1;
        t_dat = {8'd100, 8'd200};
        @(posedge clk);
        @(negedge clk);
        t_vld = 1'b0;
        lat = 0;
        while (t_ovld !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 2) begin
            n_fail++;
            $display("FAIL n2 latency: got %0d want 2", lat);
        end
        n_checks++;
        if (t_odat !== {8'd200, 8'd100}) begin
            n_fail++;
            $display("FAIL n2 data: got %h want c864", t_odat);
        end
`ifdef SEQ_SORTER_IDX_EN
        n_checks++;
        if (t_oidx !== 2'b01) begin
            n_fail++;
            $display("FAIL n2 idx: got %b want 01", t_oidx);
        end
`endif
        t_ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_ordy = 1'b0;
        n_checks++;
        if ({t_rdy, t_ovld} !== 2'b10) begin
            n_fail++;
            $display("FAIL n2 release: got %b want 10", {t_rdy, t_ovld});
        end
    endtask

    task automatic test_random;
        logic [31:0] v, ed;
        logic [7:0]  ei;
        for (int r = 0; r < 8; r++) begin
            v = $urandom();
            if (r % 3 == 0) v[15:8] = v[7:0];
            model(v, r[0], ed, ei);
            run4(r[0], v, ed, ei, r[0] ? "rand_desc" : "rand_asc");
        end
    endtask

    initial begin
        rst    = 1'b1;
        a_vld  = 1'b0; a_dat = '0; a_ordy = 1'b0;
        d_vld  = 1'b0; d_dat = '0; d_ordy = 1'b0;
        t_vld  = 1'b0; t_dat = '0; t_ordy = 1'b0;
        test_reset();
        test_spec_vectors();
        test_backpressure();
        test_reset_mid_sort();
        test_n2();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
